// File: rtl/tanh_pl_pipe.sv
// Pipelined piecewise-linear tanh/sigmoid unit, 3 stages, valid/ready on both sides.
// Define TANH_PL_STATS_EN to add the sat_count/stats_clr saturation counter.
module tanh_pl_pipe #(
    parameter int W     = 32,
    parameter int FRAC  = 24,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_y,
    output logic [TAG_W-1:0] out_tag
`ifdef TANH_PL_STATS_EN
    ,
    output logic [15:0]      sat_count,
    input  logic             stats_clr
`endif
);

    generate
        if (FRAC < 16 || FRAC > W - 4) begin : g_bad_cfg
            $error("tanh_pl_pipe: FRAC must satisfy 16 <= FRAC <= W-4");
        end
    endgenerate

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1} << FRAC;

    // tanh(k/4) in Q0.16, aligned to the top of a FRAC-bit fraction
    function automatic logic [FRAC-1:0] tk(input logic [4:0] k);
        logic [15:0]     t;
        logic [FRAC-1:0] v;
        case (k)
            5'd0:    t = 16'd0;
            5'd1:    t = 16'd16051;
            5'd2:    t = 16'd30285;
            5'd3:    t = 16'd41625;
            5'd4:    t = 16'd49912;
            5'd5:    t = 16'd55593;
            5'd6:    t = 16'd59320;
            5'd7:    t = 16'd61694;
            5'd8:    t = 16'd63179;
            5'd9:    t = 16'd64096;
            5'd10:   t = 16'd64659;
            5'd11:   t = 16'd65003;
            5'd12:   t = 16'd65212;
            5'd13:   t = 16'd65339;
            5'd14:   t = 16'd65417;
            5'd15:   t = 16'd65464;
            default: t = 16'd65492;
        endcase
        v = '0;
        v[FRAC-1 -: 16] = t;
        return v;
    endfunction

    logic w_adv;

    logic             r_v1, r_s1, r_sat1, r_mode1;
    logic [3:0]       r_i1;
    logic [FRAC-3:0]  r_r1;
    logic [TAG_W-1:0] r_tag1;

    logic             r_v2, r_s2, r_mode2;
    logic [FRAC-1:0]  r_base2, r_p2;
    logic [TAG_W-1:0] r_tag2;

    logic             r_v3;
    logic [W-1:0]     r_y3;
    logic [TAG_W-1:0] r_tag3;

    assign w_adv     = !r_v3 | out_ready;
    assign in_ready  = w_adv & rst_n;
    assign out_valid = r_v3;
    assign out_y     = r_y3;
    assign out_tag   = r_tag3;

    // S1: prescale, sign/magnitude split, segment select
    logic [W-1:0]    w_half, w_xs, w_a;
    logic            w_s, w_sat;
    logic [3:0]      w_i;
    logic [FRAC-3:0] w_r;

    assign w_half = {in_x[W-1], in_x[W-1:1]};
    assign w_xs   = in_mode ? w_half : in_x;
    assign w_s    = w_xs[W-1];
    assign w_a    = w_s ? -w_xs : w_xs;
    // most-negative input negates to itself, whose top bit lands in this range
    assign w_sat  = |w_a[W-1:FRAC+2];
    assign w_i    = w_a[FRAC+1:FRAC-2];
    assign w_r    = w_a[FRAC-3:0];

    // S2: chord slope times in-segment remainder
    logic [4:0]        w_ip1;
    logic [FRAC-1:0]   w_lo, w_hi, w_d, w_p;
    logic [2*FRAC-3:0] w_prod;

    assign w_ip1  = {1'b0, r_i1} + 5'd1;
    assign w_lo   = tk({1'b0, r_i1});
    assign w_hi   = tk(w_ip1);
    assign w_d    = w_hi - w_lo;
    assign w_prod = {{(FRAC-2){1'b0}}, w_d} * {{FRAC{1'b0}}, r_r1};
    assign w_p    = FRAC'(w_prod >> (FRAC-2));

    // S3: restore sign, optionally map tanh to sigmoid
    logic [W-1:0]        w_mw, w_t, w_y;
    logic signed [W-1:0] w_sig, w_sigh;

    assign w_mw   = {{(W-FRAC){1'b0}}, r_base2 + r_p2};
    assign w_t    = r_s2 ? -w_mw : w_mw;
    assign w_sig  = ONE + w_t;
    assign w_sigh = w_sig >>> 1;
    assign w_y    = r_mode2 ? w_sigh : w_t;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_s1    <= 1'b0;
            r_sat1  <= 1'b0;
            r_mode1 <= 1'b0;
            r_i1    <= '0;
            r_r1    <= '0;
            r_tag1  <= '0;
            r_s2    <= 1'b0;
            r_mode2 <= 1'b0;
            r_base2 <= '0;
            r_p2    <= '0;
            r_tag2  <= '0;
            r_y3    <= '0;
            r_tag3  <= '0;
        end else if (w_adv) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (in_valid) begin
                r_s1    <= w_s;
                r_sat1  <= w_sat;
                r_mode1 <= in_mode;
                r_i1    <= w_i;
                r_r1    <= w_r;
                r_tag1  <= in_tag;
            end
            if (r_v1) begin
                r_s2    <= r_s1;
                r_mode2 <= r_mode1;
                r_tag2  <= r_tag1;
                r_base2 <= r_sat1 ? tk(5'd16) : w_lo;
                r_p2    <= r_sat1 ? '0 : w_p;
            end
            if (r_v2) begin
                r_y3   <= w_y;
                r_tag3 <= r_tag2;
            end
        end
    end

`ifdef TANH_PL_STATS_EN
    logic        r_sat2, r_sat3;
    logic [15:0] r_sat_cnt;

    assign sat_count = r_sat_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat2    <= 1'b0;
            r_sat3    <= 1'b0;
            r_sat_cnt <= '0;
        end else begin
            if (w_adv && r_v1) r_sat2 <= r_sat1;
            if (w_adv && r_v2) r_sat3 <= r_sat2;
            if (stats_clr) begin
                r_sat_cnt <= '0;
            end else if (r_v3 && out_ready && r_sat3
                         && r_sat_cnt != 16'hFFFF) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tanh_pl_pipe.sv
// Scoreboard bench for tanh_pl_pipe: directed vectors, burst, stall, reset, random.
module tb_tanh_pl_pipe;
    localparam int W     = 32;
    localparam int FRAC  = 24;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_mode;
    logic [W-1:0]     in_x;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_ready;
    logic [W-1:0]     out_y;
    logic [TAG_W-1:0] out_tag;
`ifdef TANH_PL_STATS_EN
    logic [15:0]      sat_count;
    logic             stats_clr;
`endif

    tanh_pl_pipe #(.W(W), .FRAC(FRAC), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag)
`ifdef TANH_PL_STATS_EN
        ,
        .sat_count (sat_count),
        .stats_clr (stats_clr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        int               y;
        int               tol;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_checks = 0;
    int   n_errors = 0;
    int   run = 0;
    int   max_run = 0;
    bit   rnd_bp = 1'b0;

    // hand-computed vectors, Q8.24
    int dx[14] = '{0, 0, 16777216, -16777216, 83886080, 32'h80000000,
                   8388608, 2097152, 67108864, -67108864, 32'h03FFFFFF,
                   33554432, -33554432, 268435456};
    bit dm[14] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    int dy[14] = '{0, 8388608, 12777472, -12777472, 16765952, -16765952,
                   7752960, 2054528, 16765952, -16765952, 16765951,
                   14777344, 1999872, 16771584};
    // tanh(k/4)*2^16 rounded, shifted to Q.24
    int qy[16] = '{0, 4109056, 7752960, 10656000, 12777472, 14231808,
                   15185920, 15793664, 16173824, 16408576, 16552704,
                   16640768, 16694272, 16726784, 16746752, 16758784};

    task automatic check(input string name, input longint act,
                         input longint req, input longint tol);
        n_checks++;
        if (act - req > tol || req - act > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)",
                     name, act, req, tol);
        end
    endtask

    task automatic send(input logic [W-1:0] x, input logic m,
                        input logic [TAG_W-1:0] t, input int y,
                        input int tol);
        int guard = 0;
        in_x     = x;
        in_mode  = m;
        in_tag   = t;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1");
        end else begin
            sb.push_back('{t, y, tol});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 1000) begin
            guard++;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0",
                     sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) run++;
        else run = 0;
        if (run > max_run) max_run = run;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got y=%0d tag=%0d, expected none",
                         $signed(out_y), out_tag);
            end else begin
                e_mon = sb.pop_front();
                check("out_y", $signed(out_y), e_mon.y, e_mon.tol);
                check("out_tag", out_tag, e_mon.tag, 0);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_mode   = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
`ifdef TANH_PL_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0, 0);
        check("rst_out_y", out_y, 0, 0);
        check("rst_out_tag", out_tag, 0, 0);
        check("rst_in_ready", in_ready, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 14; k++)
            send(dx[k], dm[k], TAG_W'(k), dy[k], 0);
        drain();

        max_run = 0;
        for (int k = 0; k < 8; k++)
            send(k * 4194304, 1'b0, TAG_W'(k), qy[k], 0);
        drain();
        check("burst_run", max_run, 8, 0);

        fork
            begin
                for (int k = 8; k < 16; k++)
                    send(k * 4194304, 1'b0, TAG_W'(k), qy[k], 0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0, 0);
                    if (sb.size() > 0)
                        check("stall_hold_y", $signed(out_y), sb[0].y, 0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        send(16777216, 1'b0, 4'd1, 12777472, 0);
        send(33554432, 1'b0, 4'd2, 16173824, 0);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0, 0);
        check("midrst_in_ready", in_ready, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_rst_idle", out_valid, 0, 0);
        end
        @(posedge clk);
        #1;

`ifdef TANH_PL_STATS_EN
        check("sat_cnt_reset", sat_count, 0, 0);
        send(83886080, 1'b0, 4'd3, 16765952, 0);
        send(32'h80000000, 1'b0, 4'd4, -16765952, 0);
        send(16777216, 1'b0, 4'd5, 12777472, 0);
        drain();
        check("sat_cnt_two", sat_count, 2, 0);
        stats_clr = 1'b1;
        @(posedge clk);
        #1 stats_clr = 1'b0;
        @(negedge clk);
        check("sat_cnt_clr", sat_count, 0, 0);
        @(posedge clk);
        #1;
`endif

        rnd_bp = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            int  xi;
            int  ye;
            int  tol;
            bit  m;
            real xr;
            real yr;
            xi = int'($urandom) >>> 4;
            m  = 1'($urandom_range(0, 1));
            xr = $itor(xi) / 16777216.0;
            if (m) begin
                yr  = 1.0 / (1.0 + $exp(-xr));
                tol = 67108;
            end else begin
                // 0.25-wide chords deviate from tanh by up to ~0.006 near 0.6
                yr  = $tanh(xr);
                tol = 109052;
            end
            ye = $rtoi(yr * 16777216.0);
            send(xi, m, TAG_W'(n), ye, tol);
        end
        rnd_bp = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
